adder_nbit_seq: RTL and testbench

Parametrised multi-cycle N-bit unsigned adder with carry-in and overflow (carry-out), computing CHUNK_BITS of the sum per clock, LSB chunk first, with a registered ripple carry between chunks. It generalises the combinational 4-bit adder to arbitrary width and trades latency for a short carry chain. A start/busy/done handshake lets a controlling FSM issue operations back-to-back.

---
 rtl/adder_nbit_seq.sv | 113 +++++++++++
 tb/tb_adder_nbit_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbit_seq.sv
// Multi-cycle N-bit unsigned adder: CHUNK_BITS of the sum per clock, LSB chunk first,
// with a registered ripple carry between chunks and a start/busy/done handshake.
module adder_nbit_seq #(
    parameter int unsigned NUM_BITS   = 16,
    parameter int unsigned CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    localparam int unsigned NCHUNK   = NUM_BITS / CHUNK_BITS;
    localparam int unsigned IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CSUM_W   = CHUNK_BITS + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] sum_d;
    logic                carry_q, carry_d;
    logic                ovf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                accept;
    logic [31:0]         offset;
    logic [CHUNK_BITS-1:0] a_chunk, b_chunk;
    logic [CHUNK_BITS:0]   chunk_sum;

    // Current chunk slice and its carry-extended sum.
    always_comb begin
        offset    = 32'(idx_q) * CHUNK_BITS;
        a_chunk   = a_q[offset +: CHUNK_BITS];
        b_chunk   = b_q[offset +: CHUNK_BITS];
        chunk_sum = CSUM_W'(a_chunk) + CSUM_W'(b_chunk) + CSUM_W'(carry_q);
    end

    // Next-state and datapath next values; an accepted start overrides IDLE/DONE behaviour.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum;
        ovf_d   = overflow;
        accept  = start && (state_q != RUN);

        case (state_q)
            IDLE: state_d = IDLE;
            DONE: state_d = IDLE;
            RUN: begin
                sum_d[offset +: CHUNK_BITS] = chunk_sum[CHUNK_BITS-1:0];
                carry_d = chunk_sum[CHUNK_BITS];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    ovf_d   = chunk_sum[CHUNK_BITS];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = carry_in;
            idx_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
            state_d = RUN;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            sum      <= sum_d;
            overflow <= ovf_d;
            busy     <= (state_d == RUN);
            done     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Directed bench for adder_nbit_seq: 16/4 vector table plus handshake corner cases,
// and an exhaustive sweep of a 4/1 instance.
module tb_adder_nbit_seq;

    logic clk;
    logic n_rst;

    logic        start16, cin16, busy16, done16, ovf16;
    logic [15:0] a16, b16, sum16;

    logic        start4, cin4, busy4, done4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int checks   = 0;
    int failures = 0;

    adder_nbit_seq #(.NUM_BITS(16), .CHUNK_BITS(4)) dut16 (
        .clk(clk), .n_rst(n_rst), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .overflow(ovf16)
    );

    adder_nbit_seq #(.NUM_BITS(4), .CHUNK_BITS(1)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issue one 16-bit add and wait (bounded) for done; inputs are scrambled after accept.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic o, output int lat, output int nbusy);
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
        @(posedge clk);
        lat = 0; nbusy = 0; s = '0; o = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            end
            if (busy16) nbusy++;
            if (done16) begin
                lat = c; s = sum16; o = ovf16;
                break;
            end
        end
        if (lat == 0) begin
            failures++;
            $display("FAIL run16_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output logic [3:0] s, output logic o, output int lat);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; cin4 = cin;
        @(posedge clk);
        lat = 0; s = '0; o = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start4 = 1'b0;
            if (done4) begin
                lat = c; s = sum4; o = ovf4;
                break;
            end
        end
        if (lat == 0) begin
            failures++;
            $display("FAIL run4_timeout: got no done expected done within 12 cycles");
        end
    endtask

    initial begin
        logic [15:0] s;
        logic        o;
        logic [3:0]  s4;
        logic        o4;
        int          lat, nbusy, ndone;
        logic [8:0]  v;
        logic [4:0]  exp5;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[6] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0};

        n_rst = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        #1;
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_sum16",  32'(sum16),  32'd0);
        check("rst_ovf16",  32'(ovf16),  32'd0);
        check("rst_out4",   32'({busy4, done4, ovf4, sum4}), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_busy16", 32'(busy16), 32'd0);

        // Table-driven 16/4 vectors.
        for (int i = 0; i < 8; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, s, o, lat, nbusy);
            check($sformatf("vec%0d_sum", i),   32'(s),     32'(vecs[i].sum));
            check($sformatf("vec%0d_ovf", i),   32'(o),     32'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i),   32'(lat),   32'd5);
            check($sformatf("vec%0d_busy", i),  32'(nbusy), 32'd4);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 32'(done16), 32'd0);
            check($sformatf("vec%0d_hold", i),  32'({o, s}), 32'({ovf16, sum16}));
        end

        // start pulsed mid-RUN with zero operands must be ignored.
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0;
        @(posedge clk);
        ndone = 0; s = '0; o = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done16) begin
                ndone++; s = sum16; o = ovf16;
            end
            start16 = (c == 2);
            if (c == 2) begin a16 = '0; b16 = '0; end
        end
        check("ign_sum",   32'(s),     32'h5555);
        check("ign_ovf",   32'(o),     32'd0);
        check("ign_ndone", 32'(ndone), 32'd1);

        // Reset mid-RUN abandons the operation.
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy16), 32'd1);
        n_rst = 1'b0;
        #1;
        check("mrst_busy", 32'(busy16), 32'd0);
        check("mrst_done", 32'(done16), 32'd0);
        check("mrst_sum",  32'(sum16),  32'd0);
        check("mrst_ovf",  32'(ovf16),  32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done16 || busy16) ndone++;
        end
        check("mrst_quiet", 32'(ndone), 32'd0);
        run16(16'h00FF, 16'h0001, 1'b0, s, o, lat, nbusy);
        check("post_rst_sum", 32'(s),   32'h0100);
        check("post_rst_ovf", 32'(o),   32'd0);
        check("post_rst_lat", 32'(lat), 32'd5);

        // Back-to-back: start held during DONE goes straight to RUN.
        run16(16'h1234, 16'h4321, 1'b0, s, o, lat, nbusy);
        check("b2b_first_sum", 32'(s), 32'h5555);
        start16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start16 = 1'b0;
                check("b2b_nogap_busy", 32'(busy16), 32'd1);
                check("b2b_nogap_done", 32'(done16), 32'd0);
            end
            if (done16) begin
                lat = c; s = sum16; o = ovf16;
                break;
            end
        end
        check("b2b_lat", 32'(lat), 32'd5);
        check("b2b_sum", 32'(s),   32'h0000);
        check("b2b_ovf", 32'(o),   32'd1);

        // Exhaustive 4-bit, 1-bit chunks.
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            exp5 = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
            run4(v[3:0], v[7:4], v[8], s4, o4, lat);
            check($sformatf("ex4_%0d_res", i), 32'({o4, s4}), 32'(exp5));
            check($sformatf("ex4_%0d_lat", i), 32'(lat),      32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
